spi_memory_master: RTL and testbench

- SPI initiator that drives the SPIMemory responder's framing from a host on the system clock.
- Host requests one burst: read or write, 15-bit start address, byte count.
- Block serialises the 2-byte header plus data bytes (mode 0, LSB first) and streams write data in and read data out through handshakes.
- Used by the on-board controller to load and inspect SPI-attached memory.

---
 rtl/spi_memory_master.sv | 195 +++++++++++++++++++
 tb/tb_spi_memory_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_memory_master.sv
// SPI mode-0 master for SPIMemory bursts: 2-byte header {write, addr} then len data bytes, LSB first.
// Optional cur_addr output (address of the data byte in flight) when SPI_MASTER_CUR_ADDR_EN is defined.
module spi_memory_master #(
  parameter int CLK_DIV    = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  start,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  _select,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
`ifdef SPI_MASTER_CUR_ADDR_EN
  ,
  output logic [ADDR_WIDTH-1:0] cur_addr
`endif
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [LEN_WIDTH:0] FIRST_DATA = (LEN_WIDTH + 1)'(2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state_reg;
  logic [CW-1:0]         div_reg;
  logic [2:0]            bit_reg;
  logic [LEN_WIDTH:0]    byte_reg;
  logic [LEN_WIDTH:0]    last_byte_reg;
  logic                  write_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [6:0]            tx_shift_reg;
  logic [6:0]            rx_shift_reg;
  logic                  tx_wait_reg;

  logic        phase_end;
  logic        byte_end;
  logic        last_byte;
  logic [15:0] header;

  assign phase_end = (div_reg == DIV_LAST);
  assign byte_end  = (state_reg == SHIFT) && !tx_wait_reg && sck && phase_end && (bit_reg == 3'd7);
  assign last_byte = (byte_reg == last_byte_reg);
  assign header    = {write_reg, 15'(addr_reg)};

  // Consumption happens either exactly at a byte boundary (no stall) or while parked waiting for data.
  assign tx_ready = tx_valid && write_reg &&
                    (((state_reg == SHIFT) && tx_wait_reg) ||
                     (byte_end && !last_byte && (byte_reg != '0)));

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      bit_reg       <= '0;
      byte_reg      <= '0;
      last_byte_reg <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      tx_wait_reg   <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      _select       <= 1'b1;
      sck           <= 1'b0;
      mosi          <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            write_reg     <= write;
            addr_reg      <= addr;
            last_byte_reg <= {1'b0, len} + 1'b1;
            busy          <= 1'b1;
            _select       <= 1'b0;
            div_reg       <= '0;
            state_reg     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_end) begin
            div_reg      <= '0;
            bit_reg      <= '0;
            byte_reg     <= '0;
            mosi         <= header[0];
            tx_shift_reg <= header[7:1];
            state_reg    <= SHIFT;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        SHIFT: begin
          if (tx_wait_reg) begin
            if (tx_valid) begin
              tx_wait_reg  <= 1'b0;
              div_reg      <= '0;
              mosi         <= tx_data[0];
              tx_shift_reg <= tx_data[7:1];
            end
          end else if (!phase_end) begin
            div_reg <= div_reg + 1'b1;
          end else begin
            div_reg <= '0;
            if (!sck) begin
              sck          <= 1'b1;
              rx_shift_reg <= {miso, rx_shift_reg[6:1]};
              if ((bit_reg == 3'd7) && (byte_reg >= FIRST_DATA) && !write_reg) begin
                rx_data  <= {miso, rx_shift_reg};
                rx_valid <= 1'b1;
              end
            end else begin
              sck <= 1'b0;
              if (bit_reg != 3'd7) begin
                bit_reg      <= bit_reg + 1'b1;
                mosi         <= tx_shift_reg[0];
                tx_shift_reg <= {1'b0, tx_shift_reg[6:1]};
              end else begin
                bit_reg <= '0;
                if (last_byte) begin
                  mosi      <= 1'b0;
                  state_reg <= HOLD;
                end else begin
                  byte_reg <= byte_reg + 1'b1;
                  if (byte_reg == '0) begin
                    mosi         <= header[8];
                    tx_shift_reg <= header[15:9];
                  end else if (!write_reg) begin
                    mosi         <= 1'b0;
                    tx_shift_reg <= '0;
                  end else if (tx_valid) begin
                    mosi         <= tx_data[0];
                    tx_shift_reg <= tx_data[7:1];
                  end else begin
                    // Park with sck low until the host supplies the next byte.
                    tx_wait_reg <= 1'b1;
                  end
                end
              end
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            div_reg   <= '0;
            _select   <= 1'b1;
            done      <= 1'b1;
            state_reg <= GAP;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        GAP: begin
          if (phase_end) begin
            div_reg   <= '0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_CUR_ADDR_EN
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      cur_addr <= '0;
    end else if ((state_reg == IDLE) && start) begin
      cur_addr <= addr;
    end else if (byte_end && (byte_reg >= FIRST_DATA)) begin
      cur_addr <= cur_addr + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_memory_master.sv
// Self-checking bench for spi_memory_master: cycle-level timing model from the burst formulas plus an SPI responder.
`timescale 1ns/1ps
module tb_spi_memory_master;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        _reset;
  logic        start, write;
  logic [14:0] addr;
  logic [7:0]  len, tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, busy, done, _select, sck, mosi, miso;
`ifdef SPI_MASTER_CUR_ADDR_EN
  logic [14:0] cur_addr;
`endif

  always #5 clk = ~clk;

  spi_memory_master #(.CLK_DIV(D), .ADDR_WIDTH(15), .LEN_WIDTH(8)) dut (
    .clk(clk), ._reset(_reset), .start(start), .write(write), .addr(addr), .len(len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    ._select(_select), .sck(sck), .mosi(mosi), .miso(miso)
`ifdef SPI_MASTER_CUR_ADDR_EN
    , .cur_addr(cur_addr)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction description shared with the compare process
  bit          m_on = 0;
  int          cyc = 0;
  bit          m_write;
  int          m_len;
  logic [14:0] m_addr;
  logic [7:0]  m_bytes[$];
  logic [7:0]  m_rx[$];
  int          k0 = -100;
  int          stall_n = 0;

  int          n_sckp, n_txr, n_rxv, n_done, n_busy;
  logic [7:0]  rx_got[$];
  logic [7:0]  txq[$];
  logic [7:0]  use_data[$];
  bit          hs = 0;

  // SPI responder: captures mosi on rising sck, returns the low address byte for each data byte.
  logic mbits[$];
  initial miso = 1'b0;
  always @(negedge _select) begin
    mbits.delete();
    miso = 1'b0;
  end
  always @(posedge sck) begin
    n_sckp++;
    if (!_select) mbits.push_back(mosi);
  end
  always @(negedge sck) begin : resp
    int n;
    logic [14:0] ra;
    logic [7:0]  rv;
    if (!_select) begin
      n = mbits.size();
      if (n >= 16) begin
        for (int i = 0; i < 15; i++) ra[i] = mbits[i];
        ra = ra + 15'(n / 8 - 2);
        rv = ra[7:0];
        miso = rv[n % 8];
      end else begin
        miso = 1'b0;
      end
    end
  end

  function automatic logic [7:0] stream_byte(input int i);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) if (8 * i + b < mbits.size()) r[b] = mbits[8 * i + b];
    return r;
  endfunction

  // Per-cycle compare against the timing model (cycle k = period after the k-th edge following acceptance)
  always @(negedge clk) begin : cmp
    int e, n_bits, bi, b, ea, cnt;
    logic es, ek, eb, ed, et, er, mchk, em, ins;
    logic [7:0] erd, tb;
    if (m_on) begin
      n_bits = 8 * (2 + m_len);
      ins = (stall_n > 0) && (cyc > k0) && (cyc <= k0 + stall_n);
      e   = (stall_n > 0 && cyc > k0 + stall_n) ? cyc - stall_n : cyc;
      es  = (e >= 2 * D + 2 * n_bits * D);
      eb  = (e < D * (3 + 2 * n_bits));
      ed  = (e == 2 * D + 2 * n_bits * D);
      ek = 0; mchk = 0; em = 0;
      if (e >= D && e < D + 2 * n_bits * D) begin
        bi = (e - D) / (2 * D);
        ek = ((e - D) % (2 * D)) >= D;
        mchk = 1;
        tb = m_bytes[bi / 8];
        em = tb[bi % 8];
      end
      et = 0;
      if (m_write && ((e + 1 - D) % (16 * D)) == 0 && e + 1 > D) begin
        b  = (e + 1 - D) / (16 * D);
        et = (b >= 2) && (b <= m_len + 1);
      end
      if (stall_n > 0 && cyc == k0) et = 0;
      er = 0; erd = '0;
      if (!m_write && e >= 2 * D && ((e - 2 * D) % (2 * D)) == 0) begin
        bi = (e - 2 * D) / (2 * D);
        if (bi % 8 == 7 && bi / 8 >= 2 && bi / 8 < 2 + m_len) begin
          er  = 1;
          erd = m_rx[bi / 8 - 2];
        end
      end
      if (ins) begin
        es = 0; ek = 0; eb = 1; ed = 0; er = 0; mchk = 0;
        et = (cyc == k0 + stall_n);
      end
      check("ctl{sel,sck,busy,done,txr,rxv}", {_select, sck, busy, done, tx_ready, rx_valid},
            {es, ek, eb, ed, et, er});
      if (mchk) check("mosi", mosi, em);
      if (er) check("rx_data", rx_data, erd);
`ifdef SPI_MASTER_CUR_ADDR_EN
      ea  = ins ? k0 : e;
      cnt = 0;
      for (int bb = 2; bb <= m_len + 1; bb++) if (ea >= D + 16 * D * (bb + 1)) cnt++;
      check("cur_addr", cur_addr, m_addr + 15'(cnt));
`endif
      if (busy) n_busy++;
    end
    if (tx_ready && tx_valid) begin hs = 1; n_txr++; end
    if (rx_valid) begin n_rxv++; rx_got.push_back(rx_data); end
    if (done) n_done++;
  end

  task automatic run_burst(input bit w, input logic [14:0] a, input int l,
                           input int stall_j, input int stall_len, input int rst_at, input int ign_at);
    int n_bits, t_end;
    logic [14:0] ta;
    logic [7:0] d;
    m_bytes.delete(); m_rx.delete(); txq.delete(); rx_got.delete();
    m_bytes.push_back(a[7:0]);
    m_bytes.push_back({w, a[14:8]});
    for (int i = 0; i < l; i++) begin
      if (w) begin
        d = (use_data.size() > 0) ? use_data.pop_front() : 8'($urandom);
        txq.push_back(d);
        m_bytes.push_back(d);
      end else begin
        m_bytes.push_back(8'h00);
        ta = a + 15'(i);
        m_rx.push_back(ta[7:0]);
      end
    end
    m_write = w; m_len = l; m_addr = a;
    n_bits = 8 * (2 + l);
    if (stall_j >= 0) begin k0 = D + 16 * D * (stall_j + 2) - 1; stall_n = stall_len; end
    else begin k0 = -100; stall_n = 0; end
    t_end = D * (3 + 2 * n_bits) + stall_n;
    n_sckp = 0; n_txr = 0; n_rxv = 0; n_done = 0; n_busy = 0; hs = 0;

    @(posedge clk); #1;
    start = 1; write = w; addr = a; len = 8'(l); tx_valid = 0;
    @(posedge clk); #1;
    start = 0; write = 1'($urandom); addr = 15'($urandom); len = 8'($urandom);
    cyc = 0; m_on = 1;
    while (cyc <= t_end) begin
      if (hs) begin void'(txq.pop_front()); hs = 0; end
      tx_data  = (txq.size() > 0) ? txq[0] : 8'($urandom);
      tx_valid = (txq.size() > 0) && !(stall_n > 0 && cyc >= k0 && cyc < k0 + stall_n);
      start = (cyc == ign_at);
      if (start) begin write = 1'($urandom); addr = 15'($urandom); len = 8'($urandom_range(1, 9)); end
      if (cyc == rst_at) begin
        m_on = 0; start = 0;
        #2 _reset = 0;
        #1;
        check("rst_select", _select, 1'b1);
        check("rst_sck", sck, 1'b0);
        check("rst_busy_mosi_done", {busy, mosi, done, tx_ready, rx_valid}, 5'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", {_select, sck, busy}, 3'b100);
        _reset = 1; tx_valid = 0; txq.delete(); hs = 0;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
    m_on = 0; start = 0; tx_valid = 0;
    check("sck_pulses", n_sckp, n_bits);
    check("done_count", n_done, 1);
    check("tx_ready_count", n_txr, w ? l : 0);
    check("rx_valid_count", n_rxv, w ? 0 : l);
    check("stream_len", mbits.size(), n_bits);
    for (int i = 0; i < 2 + l; i++) check("stream_byte", stream_byte(i), m_bytes[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit_w[6];
    logic [7:0] lit_r[4];
    bit w;
    int l, j, sl;
    lit_w = '{8'had, 8'hde, 8'h01, 8'h02, 8'h04, 8'h08};
    lit_r = '{8'hfe, 8'hff, 8'h00, 8'h01};
    _reset = 0; start = 0; write = 0; addr = '0; len = '0; tx_data = '0; tx_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {_select, sck, mosi, busy, done, tx_ready, rx_valid}, 7'b1000000);
    check("reset_rx_data", rx_data, 8'h00);
`ifdef SPI_MASTER_CUR_ADDR_EN
    check("reset_cur_addr", cur_addr, 15'h0);
`endif
    _reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_after_release", {_select, sck, busy}, 3'b100);

    // Write 0x5ead, len 4, always-valid data
    use_data = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_burst(1'b1, 15'h5ead, 4, -1, 0, -1, -1);
    for (int i = 0; i < 6; i++) check("lit_write_stream", stream_byte(i), lit_w[i]);
    check("lit_busy_cycles", n_busy, 198);

    // Read 0x5afe, len 4
    run_burst(1'b0, 15'h5afe, 4, -1, 0, -1, -1);
    check("lit_read_hdr0", stream_byte(0), 8'hfe);
    check("lit_read_hdr1", stream_byte(1), 8'h5a);
    check("lit_read_rx_n", rx_got.size(), 4);
    for (int i = 0; i < 4 && i < rx_got.size(); i++) check("lit_read_rx", rx_got[i], lit_r[i]);

    // Read wrapping at 0x7fff
    run_burst(1'b0, 15'h7ffe, 4, -1, 0, -1, -1);
    check("lit_wrap_hdr1", stream_byte(1), 8'h7f);
    for (int i = 0; i < 4 && i < rx_got.size(); i++) check("lit_wrap_rx", rx_got[i], lit_r[i]);

    // Write with tx_valid withheld 20 cycles before the first data byte
    run_burst(1'b1, 15'h1234, 3, 0, 20, -1, -1);
    check("lit_stall_busy_cycles", n_busy, D * (3 + 16 * 5) + 20);

    // Header-only burst
    run_burst(1'b1, 15'h0421, 0, -1, 0, -1, -1);
    check("lit_len0_sck", n_sckp, 16);

    // Reset during byte 3 of a write, then clean burst with a start pulse while busy
    run_burst(1'b1, 15'h3333, 4, -1, 0, D + 2 * D * (8 * 3 + 2) + D, -1);
    run_burst(1'b0, 15'h0100, 3, -1, 0, -1, 40);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      w = 1'($urandom);
      l = $urandom_range(0, 6);
      j = -1; sl = 0;
      if (w && l > 0 && $urandom_range(0, 2) == 0) begin
        j  = $urandom_range(0, l - 1);
        sl = $urandom_range(1, 25);
      end
      run_burst(w, 15'($urandom), l, j, sl, -1, (r % 2 == 0) ? $urandom_range(5, 60) : -1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
